// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle for piso_serializer.
//   in_data    : parallel word to serialize (WIDTH bits)
//   in_valid   : in_data valid this cycle
//   in_ready   : serializer can accept a word this cycle
//   lsb_first  : bit order for the word transferred this cycle (1 = LSB first)
//   bit_out    : serial bit stream
//   bit_valid  : bit_out carries a word bit this cycle
//   word_start : first bit of each word
//   busy       : shifter or holding register occupied
// The master modport belongs to the word producer; the slave modport belongs to the serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             lsb_first;
  logic             bit_out;
  logic             bit_valid;
  logic             word_start;
  logic             busy;

  modport master (
    output in_data, in_valid, lsb_first,
    input  in_ready, bit_out, bit_valid, word_start, busy
  );

  modport slave (
    input  in_data, in_valid, lsb_first,
    output in_ready, bit_out, bit_valid, word_start, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-word holding register, giving a gap-free bit
// stream while words keep arriving.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus_io  : slave side of piso_serializer_if (word handshake in, serial stream out)
// Words are bit-reordered on capture so the shifter always shifts right and presents bit 0;
// this captures lsb_first with each word without storing the flag separately.
module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  piso_serializer_if.slave      bus_io
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              bit_out_q, bit_out_d;
  logic              bit_valid_q, bit_valid_d;
  logic              word_start_q, word_start_d;

  logic              accept;
  logic              last_bit;
  logic [WIDTH-1:0]  in_word;

  // Present the incoming word in transmit order: bit 0 goes out first.
  always_comb begin
    in_word = bus_io.in_data;
    if (!bus_io.lsb_first) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        in_word[i] = bus_io.in_data[int'(WIDTH) - 1 - i];
      end
    end
  end

  assign accept   = bus_io.in_valid && !hold_full_q;
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StShift;
          shift_d = in_word;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (!last_bit) begin
          cnt_d   = cnt_q + CntW'(1);
          shift_d = shift_q >> 1;
          if (accept) begin
            hold_d      = in_word;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // accept is impossible here since in_ready is low while hold is full
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else if (accept) begin
          shift_d = in_word;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from next-state so they align with the presented bit.
    bit_valid_d  = (state_d == StShift);
    bit_out_d    = (state_d == StShift) ? shift_d[0] : IDLE_LEVEL;
    word_start_d = (state_d == StShift) && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      bit_out_q    <= IDLE_LEVEL;
      bit_valid_q  <= 1'b0;
      word_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      word_start_q <= word_start_d;
    end
  end

  assign bus_io.in_ready   = !hold_full_q;
  assign bus_io.busy       = (state_q == StShift) || hold_full_q;
  assign bus_io.bit_out    = bit_out_q;
  assign bus_io.bit_valid  = bit_valid_q;
  assign bus_io.word_start = word_start_q;
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: bits per parallel word; legal range 2..32.
REQ-002 Parameter IDLE_LEVEL, default 1'b0: bit_out value whenever no bit is being presented.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  reset; asynchronous, active-low.
REQ-005 in_data  input  WIDTH  parallel word to serialize.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 lsb_first  input  1  bit order for the word accepted this cycle: 1 = LSB first, 0 = MSB first.
REQ-009 bit_out  output  1  serial bit stream; feeds the downstream sequence detector x input.
REQ-010 bit_valid  output  1  bit_out carries a word bit this cycle.
REQ-011 word_start  output  1  high during the first bit of each word.
REQ-012 busy  output  1  shifter or holding register occupied.

Function
REQ-013 The block SHALL accept a word on any rising edge where in_valid and in_ready are both 1; otherwise no transfer.
REQ-014 Storage SHALL be one shift register with a bit counter (0..WIDTH-1) plus one WIDTH-bit holding register with full flag; lsb_first SHALL be captured with each word.
REQ-015 in_ready SHALL equal NOT hold_full, combinationally.
REQ-016 States: IDLE (shifter empty) and SHIFT (shifter presenting bits); the holding register is independent of state.
REQ-017 Accept in IDLE: load the word directly into the shifter; go to SHIFT; the first bit appears in the cycle after the accepting edge (latency 1 cycle).
REQ-018 Accept in SHIFT with counter < WIDTH-1: load the word into the holding register; set hold_full.
REQ-019 Accept in SHIFT with counter = WIDTH-1 (last bit) and hold empty: load the word directly into the shifter; counter := 0; stay in SHIFT; no gap cycle.
REQ-020 Last bit with hold full: move holding register into shifter; clear hold_full; counter := 0; stay in SHIFT; no gap cycle.
REQ-021 Last bit with hold empty and no accept: go to IDLE.
REQ-022 In SHIFT: bit_valid = 1 and bit_out = word bit counter (LSB first) or bit WIDTH-1-counter (MSB first); counter increments by 1 each cycle.
REQ-023 In IDLE: bit_valid = 0, word_start = 0, bit_out = IDLE_LEVEL.
REQ-024 word_start = 1 exactly when bit_valid = 1 and counter = 0.
REQ-025 busy = (state = SHIFT) OR hold_full.
REQ-026 With in_valid held high, the output SHALL be a gap-free stream: n words yield exactly n*WIDTH consecutive bit_valid cycles.
REQ-027 in_data and lsb_first SHALL be ignored when no transfer occurs; held words SHALL be unaffected by later input changes.
REQ-028 bit_out, bit_valid and word_start SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-029 While reset_n = 0, the block SHALL be in IDLE with counter = 0 and hold_full = 0.
REQ-030 Reset values while reset_n = 0: bit_out = IDLE_LEVEL, bit_valid = 0, word_start = 0, busy = 0, in_ready = 1.
REQ-031 Reset asserted mid-word SHALL discard the shifter and holding-register contents immediately; no partial bits SHALL appear after release.
REQ-032 The first accept SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-033 Single word, WIDTH=8, 0x96, lsb_first=0, accepted at edge 0 -> bits 1,0,0,1,0,1,1,0 in cycles 1-8; word_start in cycle 1 only; cycle 9: bit_valid=0, bit_out=0, busy=0.
REQ-034 Same word 0x96 with lsb_first=1 -> bits 0,1,1,0,1,0,0,1 in cycles 1-8.
REQ-035 Back-to-back stream: in_valid constantly high, words 0xA5, 0x3C, 0xFF, MSB first -> bit_valid high for 24 consecutive cycles with correct bits.
REQ-036 Back-to-back stream check: in_ready = 0 from cycle 2 through the edge ending 0xA5's last bit; word_start in cycles 1, 9 and 17.
REQ-037 Late arrival: 0x01 accepted at edge 0, then 0x80 accepted on the edge ending 0x01's bit 7 (cycle 8), hold empty -> 0x80's first bit in cycle 9 with no gap and word_start = 1.
REQ-038 Reset mid-operation: reset_n pulsed low during bit 3 of the first word with hold full -> outputs at reset values immediately; after release bit_valid stays 0 until a new accept.
